urna_screen_sequencer: RTL and testbench
========================================

# urna_screen_sequencer

Top-level sequencer for the voting-machine (urna) front end. It turns keypad pulses and confirm/cancel/result buttons into a voting state machine and keeps per-candidate vote tallies. It drives the 3-bit screen code and entered digits consumed by the LCD content block. The LCD content block draws its message table only once after its reset, so this block also forces every redraw: it pulses that block's active-low reset whenever the screen changes, and holds off input until the redraw time has elapsed.

## Interface
- REDRAW_CYCLES, 10_500_000: cycles one full LCD table write takes; oBUSY length per redraw (24-bit counter).
- RST_PULSE, 16: cycles oLCD_RST_N is held low at the start of a redraw; must be < REDRAW_CYCLES.
- DONE_HOLD, 100_000_000: cycles the "confirmed" screen stays up after its redraw finishes.
- CNT_W, 8: tally width.

Ports:
- iCLK  in  1  system clock.
- iRST_N  in  1  asynchronous, active-low reset.
- iKEY_VALID  in  1  one-cycle pulse; iKEY_DIGIT is valid.
- iKEY_DIGIT  in  4  BCD digit 0-9; values 10-15 are ignored.
- iCONFIRM  in  1  one-cycle confirm pulse.
- iCANCEL  in  1  one-cycle cancel pulse.
- iSHOW_RESULT  in  1  one-cycle pulse; show the results screen.
- iTALLY_SEL  in  3  tally select: 0-3 = candidates 1-4, 4 = null, 5 = total, 6-7 = zero.
- oSCREEN  out  3  screen code for the LCD content block.
- oDIGITS  out  8  {first, second} entered BCD digits; 4'hF means not yet entered.
- oLCD_RST_N  out  1  active-low reset to the LCD content block.
- oBUSY  out  1  redraw in progress; all inputs are ignored while high.
- oTALLY  out  CNT_W  selected tally, registered.

## Operation
States and the screen each drives:
- WELCOME: screen 0.
- DIGIT1: screen 1.
- DIGIT2: screen 1.
- ASK: screen 2.
- DONE: screen 3.
- RESULT: screen 7.

Transitions (input events are evaluated only while oBUSY = 0):
- WELCOME:
  - iCONFIRM -> DIGIT1, oDIGITS = FF.
  - iSHOW_RESULT -> RESULT.
- DIGIT1:
  - valid key -> DIGIT2, oDIGITS[7:4] = digit.
- DIGIT2:
  - valid key -> ASK, oDIGITS[3:0] = digit.
- ASK:
  - iCONFIRM -> DONE, and one tally increments.
  - Vote mapping: 11/22/33/44 increment candidates 1/2/3/4; any other number increments null.
- DONE: returns to WELCOME, oDIGITS = FF, once DONE_HOLD cycles have counted after oBUSY falls.
- iCANCEL:
  - From DIGIT1, DIGIT2 or ASK -> DIGIT1, oDIGITS = FF.
  - From RESULT -> WELCOME.
  - Ignored in WELCOME and DONE.
- Simultaneous events in one cycle: priority is iCANCEL > iCONFIRM > iSHOW_RESULT > key; lower-priority events are dropped.

Tallies and the oDIGITS/redraw interaction:
- Tallies saturate at 2^CNT_W-1; an increment at max leaves the value unchanged.
- Total = saturating sum of the five tallies.
- Tallies clear only on reset.
- The DIGIT1 -> DIGIT2 transition keeps screen 1, so oSCREEN does not change and no redraw starts. oDIGITS updates, but the LCD shows the new digit only at the next redraw.

Redraw engine:
- Triggers on any change of oSCREEN, and on reset release.
- Sequence: oLCD_RST_N = 0 for RST_PULSE cycles, then 1; oBUSY = 1 for REDRAW_CYCLES cycles total, then 0.
- A new trigger cannot occur while busy, because inputs are ignored during a redraw.

## Timing
Reset values: oSCREEN = 0, oDIGITS = 8'hFF, oLCD_RST_N = 0, oBUSY = 1, oTALLY = 0, state WELCOME, all tallies 0.

After reset release:
- oLCD_RST_N rises after RST_PULSE edges.
- oBUSY falls after REDRAW_CYCLES edges.

Accepted event, all on the same (next) clock edge:
- State and oSCREEN update.
- oDIGITS updates.
- The tally increments.
- If oSCREEN changed, oLCD_RST_N goes low and oBUSY goes high.

Latency and reset behaviour:
- oTALLY has a 1-cycle latency from iTALLY_SEL or from a tally change.
- DONE -> WELCOME occurs exactly REDRAW_CYCLES + DONE_HOLD edges after the ASK confirm edge.
- Asserting reset mid-redraw or mid-vote discards the vote in progress and returns every output to its reset value asynchronously.

## Test plan
All scenarios use REDRAW_CYCLES = 20, RST_PULSE = 4, DONE_HOLD = 10.
- Reset release:
  - oLCD_RST_N low for 4 cycles.
  - oBUSY high for 20 cycles.
  - A key pulse at cycle 10 is ignored; oSCREEN = 0, oDIGITS = FF.
- Full vote (confirm, keys 2, 2, confirm):
  - oSCREEN sequence 0 -> 1 -> 2 -> 3, then 0 exactly 30 cycles after the final confirm.
  - Candidate 2 tally = 1; iTALLY_SEL = 5 reads 1.
- Vote for 57:
  - Null tally = 1; candidate tallies unchanged.
  - oDIGITS = 8'h57 on screen 2.
- iCANCEL and iCONFIRM in the same cycle in ASK: returns to DIGIT1, oDIGITS = FF, no tally change, a redraw is triggered.
- Tally saturation: with CNT_W = 2, four votes for 11 leave candidate 1 at 3.
- Reset mid-redraw: iRST_N pulsed low during DONE gives immediate reset values and a fresh 20-cycle busy window, and all tallies clear.

Source files
------------

// File: rtl/urna_screen_sequencer.sv
// Voting-machine front-end sequencer: keypad/button FSM, per-candidate tallies and
// LCD redraw control (pulses the LCD content block's reset on every screen change).
module urna_screen_sequencer #(
  parameter int unsigned REDRAW_CYCLES = 10_500_000,
  parameter int unsigned RST_PULSE     = 16,
  parameter int unsigned DONE_HOLD     = 100_000_000,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iKEY_VALID,
  input  logic [3:0]       iKEY_DIGIT,
  input  logic             iCONFIRM,
  input  logic             iCANCEL,
  input  logic             iSHOW_RESULT,
  input  logic [2:0]       iTALLY_SEL,
  output logic [2:0]       oSCREEN,
  output logic [7:0]       oDIGITS,
  output logic             oLCD_RST_N,
  output logic             oBUSY,
  output logic [CNT_W-1:0] oTALLY
);

  localparam logic [2:0] ST_WELCOME = 3'd0;
  localparam logic [2:0] ST_DIGIT1  = 3'd1;
  localparam logic [2:0] ST_DIGIT2  = 3'd2;
  localparam logic [2:0] ST_ASK     = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;
  localparam logic [2:0] ST_RESULT  = 3'd5;

  localparam logic [23:0]      LP_REDRAW    = 24'(REDRAW_CYCLES);
  localparam logic [23:0]      LP_RST_PULSE = 24'(RST_PULSE);
  localparam logic [31:0]      LP_HOLD_LAST = 32'(DONE_HOLD - 1);
  localparam logic [CNT_W-1:0] LP_CNT_MAX   = '1;

  logic [2:0]       r_state;
  logic [2:0]       r_screen;
  logic [7:0]       r_digits;
  logic [23:0]      r_redraw_cnt;
  logic             r_busy;
  logic             r_lcd_rst_n;
  logic [31:0]      r_hold_cnt;
  logic [CNT_W-1:0] r_tally [5];
  logic [CNT_W-1:0] r_tally_out;

  logic             w_key_ok;
  logic             w_ev_cancel;
  logic             w_ev_confirm;
  logic             w_ev_show;
  logic             w_ev_key;
  logic             w_hold_done;
  logic [2:0]       w_state_d;
  logic [7:0]       w_digits_d;
  logic [2:0]       w_screen_d;
  logic             w_vote;
  logic [2:0]       w_vote_idx;
  logic             w_redraw_start;
  logic [23:0]      w_redraw_inc;
  logic [CNT_W+2:0] w_sum;
  logic [CNT_W-1:0] w_total;
  logic [CNT_W-1:0] w_tally_sel;

  function automatic logic [2:0] screen_of(input logic [2:0] st);
    case (st)
      ST_WELCOME: screen_of = 3'd0;
      ST_DIGIT1:  screen_of = 3'd1;
      ST_DIGIT2:  screen_of = 3'd1;
      ST_ASK:     screen_of = 3'd2;
      ST_DONE:    screen_of = 3'd3;
      ST_RESULT:  screen_of = 3'd7;
      default:    screen_of = 3'd0;
    endcase
  endfunction

  // Strict priority: only the highest-priority pending event is considered.
  always_comb begin
    w_key_ok     = iKEY_VALID && (iKEY_DIGIT <= 4'd9);
    w_ev_cancel  = !r_busy && iCANCEL;
    w_ev_confirm = !r_busy && !iCANCEL && iCONFIRM;
    w_ev_show    = !r_busy && !iCANCEL && !iCONFIRM && iSHOW_RESULT;
    w_ev_key     = !r_busy && !iCANCEL && !iCONFIRM && !iSHOW_RESULT && w_key_ok;
    w_hold_done  = (r_state == ST_DONE) && !r_busy && (r_hold_cnt == LP_HOLD_LAST);
  end

  always_comb begin
    w_state_d  = r_state;
    w_digits_d = r_digits;
    w_vote     = 1'b0;
    case (r_state)
      ST_WELCOME: begin
        if (w_ev_confirm) begin
          w_state_d  = ST_DIGIT1;
          w_digits_d = 8'hFF;
        end else if (w_ev_show) begin
          w_state_d = ST_RESULT;
        end
      end
      ST_DIGIT1: begin
        if (w_ev_cancel) begin
          w_digits_d = 8'hFF;
        end else if (w_ev_key) begin
          w_state_d  = ST_DIGIT2;
          w_digits_d = {iKEY_DIGIT, r_digits[3:0]};
        end
      end
      ST_DIGIT2: begin
        if (w_ev_cancel) begin
          w_state_d  = ST_DIGIT1;
          w_digits_d = 8'hFF;
        end else if (w_ev_key) begin
          w_state_d  = ST_ASK;
          w_digits_d = {r_digits[7:4], iKEY_DIGIT};
        end
      end
      ST_ASK: begin
        if (w_ev_cancel) begin
          w_state_d  = ST_DIGIT1;
          w_digits_d = 8'hFF;
        end else if (w_ev_confirm) begin
          w_state_d = ST_DONE;
          w_vote    = 1'b1;
        end
      end
      ST_DONE: begin
        if (w_hold_done) begin
          w_state_d  = ST_WELCOME;
          w_digits_d = 8'hFF;
        end
      end
      ST_RESULT: begin
        if (w_ev_cancel) begin
          w_state_d = ST_WELCOME;
        end
      end
      default: begin
        w_state_d  = ST_WELCOME;
        w_digits_d = 8'hFF;
      end
    endcase
    w_screen_d     = screen_of(w_state_d);
    w_redraw_start = (w_screen_d != r_screen);
    w_redraw_inc   = r_redraw_cnt + 24'd1;
  end

  // 11/22/33/44 map to candidates 1-4 (index 0-3); everything else is a null vote.
  always_comb begin
    w_vote_idx = 3'd4;
    if ((r_digits[7:4] == r_digits[3:0]) && (r_digits[7:4] >= 4'd1) &&
        (r_digits[7:4] <= 4'd4)) begin
      w_vote_idx = 3'(r_digits[7:4] - 4'd1);
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state  <= ST_WELCOME;
      r_screen <= 3'd0;
      r_digits <= 8'hFF;
    end else begin
      r_state  <= w_state_d;
      r_screen <= w_screen_d;
      r_digits <= w_digits_d;
    end
  end

  // A screen change can only be requested while idle, so restarting here never cuts a redraw.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_redraw_cnt <= 24'd0;
      r_busy       <= 1'b1;
      r_lcd_rst_n  <= 1'b0;
    end else if (w_redraw_start) begin
      r_redraw_cnt <= 24'd0;
      r_busy       <= 1'b1;
      r_lcd_rst_n  <= 1'b0;
    end else if (r_busy) begin
      r_redraw_cnt <= w_redraw_inc;
      r_lcd_rst_n  <= (w_redraw_inc >= LP_RST_PULSE);
      r_busy       <= (w_redraw_inc < LP_REDRAW);
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_hold_cnt <= 32'd0;
    end else if (r_state != ST_DONE) begin
      r_hold_cnt <= 32'd0;
    end else if (!r_busy) begin
      r_hold_cnt <= r_hold_cnt + 32'd1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < 5; i++) begin
        r_tally[i] <= '0;
      end
    end else if (w_vote && (r_tally[w_vote_idx] != LP_CNT_MAX)) begin
      r_tally[w_vote_idx] <= r_tally[w_vote_idx] + 1'b1;
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 5; i++) begin
      w_sum = w_sum + {3'b000, r_tally[i]};
    end
    w_total = (w_sum > {3'b000, LP_CNT_MAX}) ? LP_CNT_MAX : w_sum[CNT_W-1:0];
  end

  always_comb begin
    w_tally_sel = '0;
    case (iTALLY_SEL)
      3'd0:    w_tally_sel = r_tally[0];
      3'd1:    w_tally_sel = r_tally[1];
      3'd2:    w_tally_sel = r_tally[2];
      3'd3:    w_tally_sel = r_tally[3];
      3'd4:    w_tally_sel = r_tally[4];
      3'd5:    w_tally_sel = w_total;
      default: w_tally_sel = '0;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_tally_out <= '0;
    end else begin
      r_tally_out <= w_tally_sel;
    end
  end

  assign oSCREEN    = r_screen;
  assign oDIGITS    = r_digits;
  assign oLCD_RST_N = r_lcd_rst_n;
  assign oBUSY      = r_busy;
  assign oTALLY     = r_tally_out;

endmodule

// File: tb/tb_urna_screen_sequencer.sv
// Directed bench for urna_screen_sequencer: step table plus hand-timed redraw/hold/reset sequences.
module tb_urna_screen_sequencer;

  localparam int unsigned RC = 20;
  localparam int unsigned RP = 4;
  localparam int unsigned DH = 10;
  localparam int unsigned CW = 2;

  localparam logic [2:0] EV_NONE = 3'd0;
  localparam logic [2:0] EV_CONF = 3'd1;
  localparam logic [2:0] EV_CANC = 3'd2;
  localparam logic [2:0] EV_SHOW = 3'd3;
  localparam logic [2:0] EV_KEY  = 3'd4;
  localparam logic [2:0] EV_CC   = 3'd5;

  typedef struct packed {
    logic [2:0] ev;
    logic [3:0] dig;
    logic [2:0] sel;
    logic [2:0] scr;
    logic [7:0] digs;
    logic       busy;
    logic [1:0] tal;
  } step_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          key_valid;
  logic [3:0]    key_digit;
  logic          confirm;
  logic          cancel;
  logic          show;
  logic [2:0]    sel;
  logic [2:0]    screen;
  logic [7:0]    digits;
  logic          lcd_rst_n;
  logic          busy;
  logic [CW-1:0] tally;

  int n_tests = 0;
  int n_fail  = 0;
  step_t steps[$];

  always #5 clk = ~clk;

  urna_screen_sequencer #(
    .REDRAW_CYCLES(RC),
    .RST_PULSE    (RP),
    .DONE_HOLD    (DH),
    .CNT_W        (CW)
  ) dut (
    .iCLK        (clk),
    .iRST_N      (rst_n),
    .iKEY_VALID  (key_valid),
    .iKEY_DIGIT  (key_digit),
    .iCONFIRM    (confirm),
    .iCANCEL     (cancel),
    .iSHOW_RESULT(show),
    .iTALLY_SEL  (sel),
    .oSCREEN     (screen),
    .oDIGITS     (digits),
    .oLCD_RST_N  (lcd_rst_n),
    .oBUSY       (busy),
    .oTALLY      (tally)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    key_valid = 1'b0;
    key_digit = 4'd0;
    confirm   = 1'b0;
    cancel    = 1'b0;
    show      = 1'b0;
  endtask

  task automatic drive(input logic [2:0] ev, input logic [3:0] dig);
    clear_inputs();
    case (ev)
      EV_CONF: confirm = 1'b1;
      EV_CANC: cancel = 1'b1;
      EV_SHOW: show = 1'b1;
      EV_KEY: begin
        key_valid = 1'b1;
        key_digit = dig;
      end
      EV_CC: begin
        cancel  = 1'b1;
        confirm = 1'b1;
      end
      default: ;
    endcase
  endtask

  // Wait until idle and out of the DONE screen, bounded.
  task automatic settle(input string name);
    int n = 0;
    while ((busy || screen == 3'd3) && n < 200) begin
      tick();
      n++;
    end
    n_tests++;
    if (n >= 200) begin
      n_fail++;
      $display("FAIL %s settle timeout: busy=%0b screen=%0d, want idle", name, busy, screen);
    end
  endtask

  function automatic void add(input logic [2:0] ev, input logic [3:0] dig, input logic [2:0] s,
                              input logic [2:0] scr, input logic [7:0] digs, input logic bsy,
                              input logic [1:0] tal);
    step_t st;
    st.ev   = ev;
    st.dig  = dig;
    st.sel  = s;
    st.scr  = scr;
    st.digs = digs;
    st.busy = bsy;
    st.tal  = tal;
    steps.push_back(st);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Vote 57 (null), cancel+confirm in ASK, invalid key, four votes for 11 (saturates at 3).
    add(EV_CONF, 4'd0, 3'd4, 3'd1, 8'hFF, 1'b1, 2'd0);
    add(EV_KEY,  4'd5, 3'd4, 3'd1, 8'h5F, 1'b0, 2'd0);
    add(EV_KEY,  4'd7, 3'd4, 3'd2, 8'h57, 1'b1, 2'd0);
    add(EV_CONF, 4'd0, 3'd4, 3'd3, 8'h57, 1'b1, 2'd1);
    add(EV_NONE, 4'd0, 3'd1, 3'd0, 8'hFF, 1'b0, 2'd1);
    add(EV_NONE, 4'd0, 3'd0, 3'd0, 8'hFF, 1'b0, 2'd0);
    add(EV_CONF, 4'd0, 3'd4, 3'd1, 8'hFF, 1'b1, 2'd1);
    add(EV_KEY,  4'd3, 3'd4, 3'd1, 8'h3F, 1'b0, 2'd1);
    add(EV_KEY,  4'd4, 3'd4, 3'd2, 8'h34, 1'b1, 2'd1);
    add(EV_CC,   4'd0, 3'd4, 3'd1, 8'hFF, 1'b1, 2'd1);
    add(EV_KEY,  4'hC, 3'd4, 3'd1, 8'hFF, 1'b0, 2'd1);
    add(EV_KEY,  4'd1, 3'd0, 3'd1, 8'h1F, 1'b0, 2'd0);
    add(EV_KEY,  4'd1, 3'd0, 3'd2, 8'h11, 1'b1, 2'd0);
    add(EV_CONF, 4'd0, 3'd0, 3'd3, 8'h11, 1'b1, 2'd1);
    for (int v = 2; v <= 4; v++) begin
      add(EV_CONF, 4'd0, 3'd0, 3'd1, 8'hFF, 1'b1, 2'((v - 1 > 3) ? 3 : v - 1));
      add(EV_KEY,  4'd1, 3'd0, 3'd1, 8'h1F, 1'b0, 2'((v - 1 > 3) ? 3 : v - 1));
      add(EV_KEY,  4'd1, 3'd0, 3'd2, 8'h11, 1'b1, 2'((v - 1 > 3) ? 3 : v - 1));
      add(EV_CONF, 4'd0, 3'd0, 3'd3, 8'h11, 1'b1, 2'((v > 3) ? 3 : v));
    end
    // Tallies now c1=3, c2=1, null=1; total saturates at 3.
    add(EV_NONE, 4'd0, 3'd5, 3'd0, 8'hFF, 1'b0, 2'd3);
    add(EV_NONE, 4'd0, 3'd6, 3'd0, 8'hFF, 1'b0, 2'd0);
    add(EV_NONE, 4'd0, 3'd2, 3'd0, 8'hFF, 1'b0, 2'd0);
    add(EV_NONE, 4'd0, 3'd3, 3'd0, 8'hFF, 1'b0, 2'd0);
    add(EV_NONE, 4'd0, 3'd4, 3'd0, 8'hFF, 1'b0, 2'd1);
    add(EV_NONE, 4'd0, 3'd1, 3'd0, 8'hFF, 1'b0, 2'd1);
    add(EV_SHOW, 4'd0, 3'd0, 3'd7, 8'hFF, 1'b1, 2'd3);
    add(EV_CONF, 4'd0, 3'd0, 3'd7, 8'hFF, 1'b0, 2'd3);
    add(EV_KEY,  4'd5, 3'd0, 3'd7, 8'hFF, 1'b0, 2'd3);
    add(EV_CANC, 4'd0, 3'd0, 3'd0, 8'hFF, 1'b1, 2'd3);
    add(EV_CANC, 4'd0, 3'd0, 3'd0, 8'hFF, 1'b0, 2'd3);

    rst_n = 1'b0;
    sel   = 3'd0;
    clear_inputs();
    repeat (3) tick();
    check("rst screen", 32'(screen), 32'h0);
    check("rst digits", 32'(digits), 32'hFF);
    check("rst lcd_rst_n", 32'(lcd_rst_n), 32'h0);
    check("rst busy", 32'(busy), 32'h1);
    check("rst tally", 32'(tally), 32'h0);

    // Reset release: confirm + key at cycle 10 must be ignored while busy.
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      if (k == 10) begin
        confirm   = 1'b1;
        key_valid = 1'b1;
        key_digit = 4'd5;
      end
      tick();
      clear_inputs();
      if (k == 3)  check("boot lcd low c3", 32'(lcd_rst_n), 32'h0);
      if (k == 4)  check("boot lcd high c4", 32'(lcd_rst_n), 32'h1);
      if (k == 10) check("boot ignore screen", 32'(screen), 32'h0);
      if (k == 10) check("boot ignore digits", 32'(digits), 32'hFF);
      if (k == 19) check("boot busy c19", 32'(busy), 32'h1);
      if (k == 20) check("boot busy c20", 32'(busy), 32'h0);
    end

    // Full vote for 22 with exact redraw and hold timing.
    drive(EV_CONF, 4'd0);
    tick();
    clear_inputs();
    check("v22 conf screen", 32'(screen), 32'h1);
    check("v22 conf digits", 32'(digits), 32'hFF);
    check("v22 conf busy", 32'(busy), 32'h1);
    check("v22 conf lcd", 32'(lcd_rst_n), 32'h0);
    settle("v22 a");
    drive(EV_KEY, 4'd2);
    tick();
    clear_inputs();
    check("v22 k1 screen", 32'(screen), 32'h1);
    check("v22 k1 digits", 32'(digits), 32'h2F);
    check("v22 k1 busy", 32'(busy), 32'h0);
    drive(EV_KEY, 4'd2);
    tick();
    clear_inputs();
    check("v22 k2 screen", 32'(screen), 32'h2);
    check("v22 k2 digits", 32'(digits), 32'h22);
    check("v22 k2 busy", 32'(busy), 32'h1);
    settle("v22 b");
    drive(EV_CONF, 4'd0);
    tick();
    clear_inputs();
    check("v22 done screen", 32'(screen), 32'h3);
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 19) check("v22 busy c19", 32'(busy), 32'h1);
      if (k == 20) check("v22 busy c20", 32'(busy), 32'h0);
      if (k == 29) check("v22 hold screen c29", 32'(screen), 32'h3);
      if (k == 30) begin
        check("v22 home screen c30", 32'(screen), 32'h0);
        check("v22 home digits", 32'(digits), 32'hFF);
        check("v22 home busy", 32'(busy), 32'h1);
      end
    end
    settle("v22 c");
    sel = 3'd1;
    tick();
    check("v22 tally c2", 32'(tally), 32'h1);
    sel = 3'd5;
    tick();
    check("v22 tally total", 32'(tally), 32'h1);

    foreach (steps[i]) begin
      settle($sformatf("step%0d", i));
      drive(steps[i].ev, steps[i].dig);
      sel = steps[i].sel;
      tick();
      clear_inputs();
      check($sformatf("step%0d screen", i), 32'(screen), 32'(steps[i].scr));
      check($sformatf("step%0d digits", i), 32'(digits), 32'(steps[i].digs));
      check($sformatf("step%0d busy", i), 32'(busy), 32'(steps[i].busy));
      tick();
      check($sformatf("step%0d tally", i), 32'(tally), 32'(steps[i].tal));
    end

    // Reset asserted during the DONE redraw.
    settle("mid a");
    drive(EV_CONF, 4'd0);
    tick();
    clear_inputs();
    settle("mid b");
    drive(EV_KEY, 4'd1);
    tick();
    drive(EV_KEY, 4'd2);
    tick();
    clear_inputs();
    settle("mid c");
    drive(EV_CONF, 4'd0);
    tick();
    clear_inputs();
    check("mid in done", 32'(screen), 32'h3);
    repeat (5) tick();
    rst_n = 1'b0;
    #2;
    check("mid rst screen", 32'(screen), 32'h0);
    check("mid rst digits", 32'(digits), 32'hFF);
    check("mid rst lcd", 32'(lcd_rst_n), 32'h0);
    check("mid rst busy", 32'(busy), 32'h1);
    check("mid rst tally", 32'(tally), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 3)  check("mid lcd low c3", 32'(lcd_rst_n), 32'h0);
      if (k == 4)  check("mid lcd high c4", 32'(lcd_rst_n), 32'h1);
      if (k == 19) check("mid busy c19", 32'(busy), 32'h1);
      if (k == 20) check("mid busy c20", 32'(busy), 32'h0);
    end
    sel = 3'd0;
    tick();
    check("mid tally c1", 32'(tally), 32'h0);
    sel = 3'd4;
    tick();
    check("mid tally null", 32'(tally), 32'h0);
    sel = 3'd5;
    tick();
    check("mid tally total", 32'(tally), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
